// File: rtl/facc_master.sv
// Bus master that runs one factorial-accelerator transaction per request:
// write N, set Go, poll Status, read Result, clear Go, then hand n! back over a valid/ready port.
module facc_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0800,
  parameter int          POLL_LIMIT = 64,
  parameter int          N_WIDTH    = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               req_valid,
  input  logic [N_WIDTH-1:0] req_n,
  output logic               req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic               busy,
  output logic [31:0]        bus_addr,
  output logic               bus_we,
  output logic [31:0]        bus_wd,
  input  logic [31:0]        bus_rd
);

  localparam int CW = $clog2(POLL_LIMIT) + 1;
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_LIMIT - 1);

  typedef enum logic [2:0] {IDLE, WR_N, WR_GO, POLL, RD_F, CLR_GO, RESP} state_t;

  state_t             state;
  logic [N_WIDTH-1:0] n_q;
  logic [CW-1:0]      poll_cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      n_q         <= '0;
      poll_cnt    <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          // Results are cleared here, not at the handshake, so they stay readable until the next request.
          n_q         <= req_n;
          rsp_data    <= '0;
          rsp_err     <= 1'b0;
          rsp_timeout <= 1'b0;
          state       <= WR_N;
        end
        WR_N:  state <= WR_GO;
        WR_GO: begin
          poll_cnt <= '0;
          state    <= POLL;
        end
        POLL: begin
          if (bus_rd[0]) begin
            rsp_err <= bus_rd[1];
            state   <= RD_F;
          end else if (poll_cnt == POLL_LAST) begin
            rsp_timeout <= 1'b1;
            rsp_data    <= '0;
            state       <= CLR_GO;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        RD_F: begin
          rsp_data <= bus_rd;
          state    <= CLR_GO;
        end
        CLR_GO: state <= RESP;
        RESP:   if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus side is a pure decode of the state register, so a reset silences it on the same edge.
  always_comb begin
    bus_addr = '0;
    bus_we   = 1'b0;
    bus_wd   = '0;
    case (state)
      WR_N: begin
        bus_addr = BASE_ADDR;
        bus_we   = 1'b1;
        bus_wd   = 32'(n_q);
      end
      WR_GO: begin
        bus_addr = BASE_ADDR + 32'h4;
        bus_we   = 1'b1;
        bus_wd   = 32'h1;
      end
      POLL:   bus_addr = BASE_ADDR + 32'h8;
      RD_F:   bus_addr = BASE_ADDR + 32'hC;
      CLR_GO: begin
        bus_addr = BASE_ADDR + 32'h4;
        bus_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

endmodule
